// File: rtl/pixel_stream_source.sv
// Ready/valid raster source: reads a frame from a 1-cycle-latency RAM into a 2-entry skid buffer with SOF/EOL tags.
// Optional: define PIXEL_SRC_REPEAT_EN to add repeat_mode (back-to-back frames without a gap).
module pixel_stream_source #(
   parameter int DATA_WIDTH = 2,
   parameter int ADDR_WIDTH = 8,
   parameter int DIM_WIDTH  = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DIM_WIDTH-1:0]  cfg_width,
   input  logic [DIM_WIDTH-1:0]  cfg_height,
`ifdef PIXEL_SRC_REPEAT_EN
   input  logic                  repeat_mode,
`endif
   output logic                  busy,
   output logic                  done,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  i_r_ready,
   input  logic                  u_r_ready,
   output logic                  sof,
   output logic                  eol
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   typedef struct packed {
      logic                  last;
      logic                  eol;
      logic                  sof;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   state_t                r_state;
   logic [DIM_WIDTH-1:0]  r_w, r_h, r_row, r_col;
   logic [ADDR_WIDTH-1:0] r_addr;
   entry_t                r_b0, r_b1;
   logic [1:0]            r_occ;
   logic                  r_inflight, r_if_sof, r_if_eol, r_if_last;
   logic                  r_busy, r_done;

   logic                  w_pop, w_rd_en, w_last_rd, w_repeat, w_col_end;
   logic [2:0]            w_level;
   entry_t                w_new;

`ifdef PIXEL_SRC_REPEAT_EN
   assign w_repeat = repeat_mode;
`else
   assign w_repeat = 1'b0;
`endif

   // Issue a read only if the buffer can still hold it after this edge's pop.
   always_comb begin
      w_pop     = (r_occ != 2'd0) && u_r_ready;
      w_level   = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
      w_rd_en   = (r_state == RUN) && (w_level < 3'd2);
      w_col_end = (r_col == r_w - DIM_WIDTH'(1));
      w_last_rd = (r_row == r_h - DIM_WIDTH'(1)) && w_col_end;
      w_new     = {r_if_last, r_if_eol, r_if_sof, mem_rd_data};
   end

   always_comb begin
      busy        = r_busy;
      done        = r_done;
      mem_rd_en   = w_rd_en;
      mem_rd_addr = r_addr;
      i_r_ready   = (r_occ != 2'd0);
      data_out    = i_r_ready ? r_b0.data : '0;
      sof         = i_r_ready & r_b0.sof;
      eol         = i_r_ready & r_b0.eol;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= IDLE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_occ      <= 2'd0;
         r_inflight <= 1'b0;
         r_if_sof   <= 1'b0;
         r_if_eol   <= 1'b0;
         r_if_last  <= 1'b0;
         r_addr     <= '0;
         r_row      <= '0;
         r_col      <= '0;
         r_w        <= '0;
         r_h        <= '0;
         r_b0       <= '0;
         r_b1       <= '0;
      end else begin
         r_done     <= w_pop && r_b0.last;
         r_inflight <= w_rd_en;

         unique case ({r_inflight, w_pop})
            2'b10: begin
               if (r_occ == 2'd0) r_b0 <= w_new;
               else               r_b1 <= w_new;
               r_occ <= r_occ + 2'd1;
            end
            2'b01: begin
               r_b0  <= r_b1;
               r_occ <= r_occ - 2'd1;
            end
            2'b11: begin
               if (r_occ == 2'd1) r_b0 <= w_new;
               else begin
                  r_b0 <= r_b1;
                  r_b1 <= w_new;
               end
            end
            default: ;
         endcase

         if (w_rd_en) begin
            r_if_sof  <= (r_row == '0) && (r_col == '0);
            r_if_eol  <= w_col_end;
            r_if_last <= w_last_rd;
         end

         case (r_state)
            IDLE: begin
               if (start) begin
                  if ((cfg_width != '0) && (cfg_height != '0)) begin
                     r_w     <= cfg_width;
                     r_h     <= cfg_height;
                     r_addr  <= '0;
                     r_row   <= '0;
                     r_col   <= '0;
                     r_busy  <= 1'b1;
                     r_state <= RUN;
                  end else begin
                     r_done <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (w_rd_en) begin
                  if (w_last_rd) begin
                     r_row  <= '0;
                     r_col  <= '0;
                     r_addr <= w_repeat ? '0 : r_addr + ADDR_WIDTH'(1);
                     if (!w_repeat) r_state <= DRAIN;
                  end else begin
                     r_addr <= r_addr + ADDR_WIDTH'(1);
                     if (w_col_end) begin
                        r_col <= '0;
                        r_row <= r_row + DIM_WIDTH'(1);
                     end else begin
                        r_col <= r_col + DIM_WIDTH'(1);
                     end
                  end
               end
            end
            DRAIN: begin
               if (w_pop && r_b0.last) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/pixel_stream_source.md
Name: pixel_stream_source

Overview:
- Transmit end of the ISP ready/valid pixel stream: reads a raster frame from a synchronous 1-cycle-latency buffer RAM and drives it into the head of a fifo_shell chain.
- Provides SOF/EOL sideband and full backpressure support; sustains 1 pixel/cycle when downstream is always ready.
- Started by a single pulse; reports busy/done to the ISP controller.

Parameters:
- DATA_WIDTH, 2, pixel width; matches fifo_shell DATA_WIDTH.
- ADDR_WIDTH, 8, RAM address width.
- DIM_WIDTH, 8, width of cfg_width/cfg_height and internal row/col counters.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  frame start request, sampled when idle.
- cfg_width  input  DIM_WIDTH  pixels per row, latched on accepted start.
- cfg_height  input  DIM_WIDTH  rows per frame, latched on accepted start.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse, frame complete.
- mem_rd_en  output  1  RAM read strobe.
- mem_rd_addr  output  ADDR_WIDTH  RAM read address.
- mem_rd_data  input  DATA_WIDTH  RAM data, valid the cycle after mem_rd_en.
- data_out  output  DATA_WIDTH  pixel to downstream (fifo_shell data_in).
- i_r_ready  output  1  output valid (drives fifo_shell u_i_ready).
- u_r_ready  input  1  downstream ready (from fifo_shell i_i_ready).
- sof  output  1  qualifies first pixel of frame.
- eol  output  1  qualifies last pixel of each row.

Behaviour:
- Interface rule: one clock, `clock`; reset is synchronous and active-high, port `reset`.
- Reset: busy, done, mem_rd_en, i_r_ready, sof, eol, data_out, mem_rd_addr = 0. FSM goes to IDLE, the buffer is emptied, and the in-flight flag is cleared. A reset asserted mid-frame aborts the frame, with outputs 0 the following cycle.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN: start=1 and cfg_width!=0 and cfg_height!=0. Latch dims, set addr=0, row=col=0, busy=1.
  - start=1 with either dim 0: stay IDLE, no reads, done=1 next cycle.
  - RUN -> DRAIN: the read for the last pixel (row=h-1, col=w-1) is issued.
  - DRAIN -> IDLE: the last pixel is accepted downstream. busy=0 and done=1 in the cycle after acceptance.
  - start while busy is ignored.
- Read issue: 2-entry output buffer plus 1 in-flight flag. In RUN, mem_rd_en = (occupancy + inflight - pop) < 2, where pop = i_r_ready & u_r_ready. mem_rd_en may depend combinationally on u_r_ready.
- Address and counters:
  - mem_rd_addr increments by 1 per issued read and wraps modulo 2^ADDR_WIDTH.
  - col increments per read; at w-1 it wraps to 0 and row increments.
- Tags: sof/eol are computed at issue time and carried with the read into the buffer entry. mem_rd_data is captured into the buffer at the edge ending the cycle after the read.
- Output:
  - i_r_ready = buffer non-empty (registered, never combinational from u_r_ready).
  - data_out/sof/eol come from the buffer head. They stay stable while i_r_ready=1 and u_r_ready=0.
  - A transfer occurs on i_r_ready & u_r_ready. sof/eol are 0 whenever i_r_ready=0.
- Latency: start sampled in cycle k -> mem_rd_en in k+1 -> i_r_ready in k+3.
- Throughput: steady state with u_r_ready=1 is one pixel per cycle, no bubbles.
- Simultaneous capture and pop on the same edge: occupancy unchanged and order preserved. The buffer never overflows.

Optional Feature:
- Macro: PIXEL_SRC_REPEAT_EN.
- Defined:
  - Adds input `repeat_mode` (1 bit).
  - If repeat_mode=1 when the last read issues, the FSM stays in RUN. Address, row and col restart at 0 with no gap, and the next pixel carries sof.
  - done still pulses once per frame, one cycle after each frame's last accept. busy stays 1.
  - Deasserting repeat_mode finishes the current frame normally.
- Undefined: no port; single-frame behaviour only.

Test Plan:
- Reset: assert reset 2 cycles with start=1 -> all outputs 0, no mem_rd_en, FSM idle.
- Basic frame: RAM returns addr[1:0], width=4, height=2, u_r_ready=1, start pulse in cycle k:
  - i_r_ready rises at k+3; data 0,1,2,3,0,1,2,3 on 8 consecutive cycles.
  - sof on pixel 0; eol on pixels 3 and 7.
  - done=1 and busy=0 one cycle after pixel 7.
- Backpressure: same frame, u_r_ready pattern 1,0,0,1,0,1... -> exactly 8 transfers in order. Data/tags held during stalls. Occupancy+inflight never exceeds 2.
- Edge cases:
  - start during frame is ignored, with the frame unaltered.
  - start with cfg_width=0 -> done next cycle, mem_rd_en never asserted.
- Reset mid-frame after 3 transfers -> outputs 0 next cycle. A new start gives sof with data from addr 0.
- With PIXEL_SRC_REPEAT_EN, repeat_mode=1, 2x2 frame -> continuous 0,1,2,3,0,1,... with sof every 4th pixel and done every 4 accepts.
